// File: rtl/dds_freq_scheduler.sv
// dds_freq_scheduler
//   Sequences every frequency-word update between the rotary encoder, the
//   tuning-table LUT and the oscillator. A manual requester (encoder) and an
//   internal sweep engine compete for the update FSM. Manual always wins.
//   Each granted update drives Address, waits out the LUT read latency, then
//   fires FreqChng in the first cycle Ready is high.
//
//   Optional build macro: SWEEP_PINGPONG_EN
//     Defined   -> the sweep bounces between Sweep_Start and Sweep_Stop.
//     Undefined -> the sweep wraps from Sweep_Stop back to Sweep_Start.
//
// Ports (all synchronous to Fg_CLK rising edge):
//   RESET        in   synchronous active-high reset
//   Man_Addr     in   encoder address, valid with Man_Chng
//   Man_Chng     in   single-cycle manual request strobe
//   Sweep_En     in   level, enables the sweep engine
//   Sweep_Start  in   first sweep address
//   Sweep_Stop   in   last sweep address
//   Dwell        in   Ready pulses per sweep step (0 behaves as 1)
//   Ready        in   oscillator sample strobe
//   Address      out  registered LUT address
//   FreqChng     out  single-cycle oscillator reload strobe
//   Busy         out  FSM is not IDLE
//   Sweep_Active out  sweep engine running
//   Sweep_Wrap   out  single-cycle pulse on a sweep wrap / reversal step
//
// Handshake: Man_Chng is a one-cycle strobe with no back-pressure; a strobe
// arriving while busy is parked in a one-deep slot (last strobe wins).
// FreqChng is only raised in ARM, in the same cycle Ready is sampled high.

module dds_freq_scheduler #(
    parameter int ADDR_W  = 11,
    parameter int DWELL_W = 16,
    parameter int LUT_LAT = 2
) (
    input  logic               Fg_CLK,
    input  logic               RESET,
    input  logic [ADDR_W-1:0]  Man_Addr,
    input  logic               Man_Chng,
    input  logic               Sweep_En,
    input  logic [ADDR_W-1:0]  Sweep_Start,
    input  logic [ADDR_W-1:0]  Sweep_Stop,
    input  logic [DWELL_W-1:0] Dwell,
    input  logic               Ready,
    output logic [ADDR_W-1:0]  Address,
    output logic               FreqChng,
    output logic               Busy,
    output logic               Sweep_Active,
    output logic               Sweep_Wrap
);

    typedef enum logic [1:0] {IDLE, LOAD, LUT_WAIT, ARM} state_t;

    localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
    localparam logic [DWELL_W:0]   DWELL_ONE = (DWELL_W+1)'(1);
    localparam logic [2:0]         LAT_LAST  = 3'(LUT_LAT - 1);

    state_t              state_q, state_d;
    logic [2:0]          lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic                sweep_req_q, sweep_req_d;
    logic                active_q, active_d;
    logic                wrap_q, wrap_d;
    logic                freq_chng;

    logic                man_req;
    logic [ADDR_W-1:0]   man_addr;
    logic [DWELL_W:0]    dwell_eff;
    logic [DWELL_W:0]    cnt_inc;
    logic                parked;
    logic                tick;
    logic                expire;
    logic [ADDR_W-1:0]   step_ptr;
    logic                step_wrap;

`ifdef SWEEP_PINGPONG_EN
    logic                dir_q, dir_d;   // 1 = counting up
    logic                step_dir;

    // Bounce at the endpoints; >=/<= keeps a pointer that ended up outside
    // the window (live Start/Stop change) heading back toward it.
    always_comb begin
        step_dir  = dir_q;
        step_wrap = 1'b0;
        step_ptr  = ptr_q;
        if (dir_q) begin
            if (ptr_q >= Sweep_Stop) begin
                step_ptr  = ptr_q - ADDR_ONE;
                step_dir  = 1'b0;
                step_wrap = 1'b1;
            end else begin
                step_ptr  = ptr_q + ADDR_ONE;
            end
        end else begin
            if (ptr_q <= Sweep_Start) begin
                step_ptr  = ptr_q + ADDR_ONE;
                step_dir  = 1'b1;
                step_wrap = 1'b1;
            end else begin
                step_ptr  = ptr_q - ADDR_ONE;
            end
        end
    end
`else
    always_comb begin
        step_wrap = 1'b0;
        step_ptr  = ptr_q + ADDR_ONE;
        if (ptr_q == Sweep_Stop) begin
            step_ptr  = Sweep_Start;
            step_wrap = 1'b1;
        end
    end
`endif

    always_comb begin
        man_req   = Man_Chng | pend_q;
        man_addr  = Man_Chng ? Man_Addr : pend_addr_q;
        dwell_eff = (Dwell == '0) ? DWELL_ONE : {1'b0, Dwell};
        cnt_inc   = {1'b0, dwell_cnt_q} + DWELL_ONE;
        parked    = (Sweep_Start >= Sweep_Stop);
        // Dwell only advances on idle Ready pulses that are not already
        // being used to grant some other request.
        tick      = (state_q == IDLE) && active_q && Sweep_En && Ready &&
                    !man_req && !sweep_req_q;
        expire    = tick && (cnt_inc >= dwell_eff);
    end

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        target_d    = target_q;
        address_d   = address_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        ptr_d       = ptr_q;
        dwell_cnt_d = dwell_cnt_q;
        sweep_req_d = sweep_req_q;
        active_d    = Sweep_En;
        wrap_d      = 1'b0;
        freq_chng   = 1'b0;
`ifdef SWEEP_PINGPONG_EN
        dir_d       = dir_q;
`endif

        if (!Sweep_En) begin
            sweep_req_d = 1'b0;
        end else if (!active_q) begin
            // Sweep enable rising: reload and request the first step.
            ptr_d       = Sweep_Start;
            sweep_req_d = 1'b1;
            dwell_cnt_d = '0;
`ifdef SWEEP_PINGPONG_EN
            dir_d       = 1'b1;
`endif
        end

        if (state_q != IDLE && Man_Chng) begin
            pend_d      = 1'b1;
            pend_addr_d = Man_Addr;
        end

        unique case (state_q)
            IDLE: begin
                if (man_req) begin
                    target_d    = man_addr;
                    pend_d      = 1'b0;
                    dwell_cnt_d = '0;
                    sweep_req_d = 1'b0;
                    state_d     = LOAD;
                end else if (sweep_req_q && Sweep_En) begin
                    target_d    = ptr_q;
                    sweep_req_d = 1'b0;
                    state_d     = LOAD;
                end else if (expire) begin
                    dwell_cnt_d = '0;
                    if (parked) begin
                        ptr_d = Sweep_Start;
                    end else begin
                        target_d = step_ptr;
                        ptr_d    = step_ptr;
                        wrap_d   = step_wrap;
                        state_d  = LOAD;
`ifdef SWEEP_PINGPONG_EN
                        dir_d    = step_dir;
`endif
                    end
                end else if (tick) begin
                    dwell_cnt_d = cnt_inc[DWELL_W-1:0];
                end
            end
            LOAD: begin
                address_d = target_q;
                lat_cnt_d = '0;
                state_d   = LUT_WAIT;
            end
            LUT_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = ARM;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            ARM: begin
                if (Ready) begin
                    freq_chng = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Fg_CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            target_q    <= '0;
            address_q   <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            ptr_q       <= '0;
            dwell_cnt_q <= '0;
            sweep_req_q <= 1'b0;
            active_q    <= 1'b0;
            wrap_q      <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
            dir_q       <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            target_q    <= target_d;
            address_q   <= address_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            ptr_q       <= ptr_d;
            dwell_cnt_q <= dwell_cnt_d;
            sweep_req_q <= sweep_req_d;
            active_q    <= active_d;
            wrap_q      <= wrap_d;
`ifdef SWEEP_PINGPONG_EN
            dir_q       <= dir_d;
`endif
        end
    end

    assign Address      = address_q;
    assign FreqChng     = freq_chng;
    assign Busy         = (state_q != IDLE);
    assign Sweep_Active = active_q;
    assign Sweep_Wrap   = wrap_q;

endmodule

// File: tb/tb_dds_freq_scheduler.sv
module tb_dds_freq_scheduler;

  localparam int ADDR_W  = 11;
  localparam int DWELL_W = 16;

  logic               Fg_CLK = 1'b0;
  logic               RESET;
  logic [ADDR_W-1:0]  Man_Addr;
  logic               Man_Chng;
  logic               Sweep_En;
  logic [ADDR_W-1:0]  Sweep_Start;
  logic [ADDR_W-1:0]  Sweep_Stop;
  logic [DWELL_W-1:0] Dwell;
  logic               Ready;
  logic [ADDR_W-1:0]  Address;
  logic               FreqChng;
  logic               Busy;
  logic               Sweep_Active;
  logic               Sweep_Wrap;

  dds_freq_scheduler #(.ADDR_W(ADDR_W), .DWELL_W(DWELL_W), .LUT_LAT(2)) dut (
    .Fg_CLK(Fg_CLK), .RESET(RESET), .Man_Addr(Man_Addr), .Man_Chng(Man_Chng),
    .Sweep_En(Sweep_En), .Sweep_Start(Sweep_Start), .Sweep_Stop(Sweep_Stop),
    .Dwell(Dwell), .Ready(Ready), .Address(Address), .FreqChng(FreqChng),
    .Busy(Busy), .Sweep_Active(Sweep_Active), .Sweep_Wrap(Sweep_Wrap)
  );

  // clock / watchdog
  always #5 Fg_CLK = ~Fg_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // counters and scoreboard
  int total = 0;
  int bad   = 0;
  logic [ADDR_W-1:0] exp_q[$];
  int gap_q[$];
  logic [ADDR_W-1:0] wrap_addr_q[$];
  int fc_cnt    = 0;
  int wrap_cnt  = 0;
  int unexp_cnt = 0;
  int rdy_gap   = 0;
  bit wrap_seen = 0;
  bit seen_20   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Ready generator: 0 = low, 1 = tied high, 2 = one pulse every 4 cycles
  int ready_mode = 0;
  int rcnt = 0;
  initial begin
    Ready = 1'b0;
    forever begin
      @(posedge Fg_CLK);
      #1;
      rcnt++;
      Ready = (ready_mode == 1) || (ready_mode == 2 && (rcnt % 4) == 0);
    end
  end

  // monitor: every FreqChng must carry the next expected address
  initial begin
    logic [ADDR_W-1:0] e;
    forever begin
      @(negedge Fg_CLK);
      if (Address == 11'h020) seen_20 = 1;
      if (FreqChng === 1'b1) begin
        fc_cnt++;
        gap_q.push_back(rdy_gap);
        rdy_gap = 0;
        if (wrap_seen) begin
          wrap_addr_q.push_back(Address);
          wrap_seen = 0;
        end
        if (exp_q.size() == 0) begin
          unexp_cnt++;
        end else begin
          e = exp_q.pop_front();
          chk("fc_addr", 32'(Address), 32'(e));
        end
      end else if (Ready === 1'b1) begin
        rdy_gap++;
      end
      if (Sweep_Wrap === 1'b1) begin
        wrap_cnt++;
        wrap_seen = 1;
      end
    end
  end

  // driver tasks
  task automatic nxt();
    @(posedge Fg_CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge Fg_CLK);
    #1;
  endtask

  task automatic wait_fc(input int target, input int budget, input string tag);
    int n = 0;
    while (fc_cnt < target && n < budget) begin
      smp();
      n++;
    end
    chk(tag, fc_cnt, target);
  endtask

  initial begin
    int base;
    int wbase;
    int n;
    RESET = 1'b1; Man_Addr = '0; Man_Chng = 1'b0; Sweep_En = 1'b0;
    Sweep_Start = '0; Sweep_Stop = '0; Dwell = '0;

    // reset state
    repeat (3) nxt();
    smp();
    chk("rst_addr", 32'(Address), 0);
    chk("rst_fc", 32'(FreqChng), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_active", 32'(Sweep_Active), 0);
    chk("rst_wrap", 32'(Sweep_Wrap), 0);
    nxt();
    RESET = 1'b0;
    ready_mode = 1;
    repeat (2) nxt();

    // single manual update, Ready high: FreqChng 4 cycles after strobe
    exp_q.push_back(11'h155);
    Man_Chng = 1'b1; Man_Addr = 11'h155;
    for (int k = 0; k < 6; k++) begin
      smp();
      chk($sformatf("t1_fc_c%0d", k), 32'(FreqChng), (k == 4) ? 1 : 0);
      chk($sformatf("t1_busy_c%0d", k), 32'(Busy), (k >= 1 && k <= 4) ? 1 : 0);
      if (k == 2) chk("t1_addr", 32'(Address), 32'h155);
      nxt();
      Man_Chng = 1'b0;
    end

    // overlapping strobes: last pending wins
    base = fc_cnt;
    seen_20 = 0;
    exp_q.push_back(11'h010);
    exp_q.push_back(11'h030);
    Man_Chng = 1'b1; Man_Addr = 11'h010;
    nxt(); Man_Addr = 11'h020;
    nxt(); Man_Addr = 11'h030;
    nxt(); Man_Chng = 1'b0;
    repeat (12) nxt();
    chk("t2_fc_count", fc_cnt - base, 2);
    chk("t2_addr", 32'(Address), 32'h030);
    chk("t2_no_020", 32'(seen_20), 0);

    // wrap sweep 5..7, dwell 3
    ready_mode = 2;
    Sweep_Start = 11'd5; Sweep_Stop = 11'd7; Dwell = 16'd3;
    base = fc_cnt; wbase = wrap_cnt;
    gap_q.delete(); wrap_addr_q.delete();
    exp_q.push_back(11'd5); exp_q.push_back(11'd6); exp_q.push_back(11'd7);
    exp_q.push_back(11'd5); exp_q.push_back(11'd6);
    Sweep_En = 1'b1;
    nxt();
    smp();
    chk("t3_active", 32'(Sweep_Active), 1);
    wait_fc(base + 5, 300, "t3_steps");
    nxt(); Sweep_En = 1'b0;
    chk("t3_gap_n", gap_q.size(), 5);
    for (int i = 1; i < 5 && i < gap_q.size(); i++)
      chk($sformatf("t3_gap%0d", i), gap_q[i], 3);
    chk("t3_wraps", wrap_cnt - wbase, 1);
    if (wrap_addr_q.size() > 0) chk("t3_wrap_tgt", 32'(wrap_addr_q[0]), 5);
    repeat (2) nxt();
    smp();
    chk("t3_inactive", 32'(Sweep_Active), 0);
    repeat (20) nxt();
    chk("t3_stopped", fc_cnt - base, 5);

    // manual strobe coinciding with dwell expiry at pointer 6
    base = fc_cnt;
    exp_q.push_back(11'd5); exp_q.push_back(11'd6);
    Sweep_En = 1'b1;
    wait_fc(base + 2, 200, "t4_reach6");
    n = 0;
    for (int b = 0; b < 40 && n < 2; b++) begin
      smp();
      if (Ready) n++;
    end
    repeat (4) nxt();
    exp_q.push_back(11'h100); exp_q.push_back(11'd7);
    Man_Chng = 1'b1; Man_Addr = 11'h100;
    nxt(); Man_Chng = 1'b0;
    wait_fc(base + 4, 200, "t4_steps");
    nxt(); Sweep_En = 1'b0;
    if (gap_q.size() > 0) chk("t4_gap7", gap_q[$], 3);
    repeat (20) nxt();

    // reset mid-update aborts it
    ready_mode = 1;
    base = fc_cnt;
    Man_Chng = 1'b1; Man_Addr = 11'h3ab;
    nxt(); Man_Chng = 1'b0;
    nxt(); RESET = 1'b1;
    nxt(); RESET = 1'b0;
    smp();
    chk("t5_addr", 32'(Address), 0);
    chk("t5_busy", 32'(Busy), 0);
    chk("t5_fc", 32'(FreqChng), 0);
    chk("t5_active", 32'(Sweep_Active), 0);
    chk("t5_wrap", 32'(Sweep_Wrap), 0);
    repeat (8) nxt();
    chk("t5_no_fc", fc_cnt - base, 0);

    // Start >= Stop: single load, then parked
    Sweep_Start = 11'd9; Sweep_Stop = 11'd4; Dwell = 16'd1;
    exp_q.push_back(11'd9);
    Sweep_En = 1'b1;
    repeat (40) nxt();
    chk("t5_parked_fc", fc_cnt - base, 1);
    chk("t5_parked_addr", 32'(Address), 9);
    Sweep_En = 1'b0;
    repeat (4) nxt();

    // endpoint behaviour, 2..4, short dwell
    ready_mode = 2;
    Sweep_Start = 11'd2; Sweep_Stop = 11'd4;
    base = fc_cnt; wbase = wrap_cnt;
    gap_q.delete(); wrap_addr_q.delete();
`ifdef SWEEP_PINGPONG_EN
    Dwell = 16'd1;
    exp_q.push_back(11'd2); exp_q.push_back(11'd3); exp_q.push_back(11'd4);
    exp_q.push_back(11'd3); exp_q.push_back(11'd2); exp_q.push_back(11'd3);
    n = 6;
`else
    Dwell = 16'd0;
    exp_q.push_back(11'd2); exp_q.push_back(11'd3); exp_q.push_back(11'd4);
    exp_q.push_back(11'd2); exp_q.push_back(11'd3);
    n = 5;
`endif
    Sweep_En = 1'b1;
    wait_fc(base + n, 300, "t6_steps");
    nxt(); Sweep_En = 1'b0;
    for (int i = 1; i < n && i < gap_q.size(); i++)
      chk($sformatf("t6_gap%0d", i), gap_q[i], 1);
`ifdef SWEEP_PINGPONG_EN
    chk("t6_wraps", wrap_cnt - wbase, 2);
    chk("t6_wrap_n", wrap_addr_q.size(), 2);
    if (wrap_addr_q.size() > 1) begin
      chk("t6_turn_top", 32'(wrap_addr_q[0]), 3);
      chk("t6_turn_bot", 32'(wrap_addr_q[1]), 3);
    end
`else
    chk("t6_wraps", wrap_cnt - wbase, 1);
    if (wrap_addr_q.size() > 0) chk("t6_wrap_tgt", 32'(wrap_addr_q[0]), 2);
`endif
    repeat (20) nxt();

    // final report
    chk("unexpected_fc", unexp_cnt, 0);
    chk("exp_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
